// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises rst_in, stretches the hold, then releases NUM_CH domains in order.
// Build with RESET_SEQ_CAUSE_EN defined to add the sticky last-reset-cause register (cause_clr / rst_cause).
//
// state      | meaning
// ST_HOLD    | all domains in reset; stretch counter runs once rst_in is synchronised
// ST_RELEASE | domains released one every STAGE_GAP cycles, ascending index
// ST_RUN     | all domains out of reset except channels in a soft pulse
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 8,
  parameter int CH_PULSE       = 4
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              seq_busy
`ifdef RESET_SEQ_CAUSE_EN
  ,
  input  logic              cause_clr,
  output logic [1:0]        rst_cause
`endif
);

  localparam int SEQ_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(SEQ_MAX + 1) + 1;
  localparam int PW      = $clog2(CH_PULSE + 1) + 1;
  localparam int IW      = $clog2(NUM_CH + 1) + 1;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [SYNC_STAGES-1:0]      sync_q, sync_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [NUM_CH-1:0][PW-1:0]   pcnt_q, pcnt_d;
  logic [NUM_CH-1:0]           rst_n_q, rst_n_d;
  logic                        busy_q, busy_d;
  logic                        sync_ok;

  assign sync_ok = sync_q[SYNC_STAGES-1];
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    rst_n_d = rst_n_q;
    if (!sync_ok) begin
      state_d = ST_HOLD;
    end else if (sw_rst_req) begin
      // The request edge itself counts as the first hold cycle.
      state_d = ST_HOLD;
      cnt_d   = CW'(1);
      idx_d   = '0;
      pcnt_d  = '0;
      rst_n_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == CW'(STRETCH_CYCLES)) begin
            rst_n_d[0] = 1'b1;
            cnt_d      = CW'(1);
            idx_d      = IW'(1);
            state_d    = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == CW'(STAGE_GAP)) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (idx_q == IW'(k)) rst_n_d[k] = 1'b1;
            end
            cnt_d = CW'(1);
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(NUM_CH - 1)) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          // A fresh request restarts the channel's pulse, even on its terminal cycle.
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch_rst_req[i]) begin
              pcnt_d[i]  = PW'(1);
              rst_n_d[i] = 1'b0;
            end else if (pcnt_q[i] == PW'(CH_PULSE)) begin
              pcnt_d[i]  = '0;
              rst_n_d[i] = 1'b1;
            end else if (pcnt_q[i] != '0) begin
              pcnt_d[i] = pcnt_q[i] + PW'(1);
            end
          end
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          rst_n_d = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      sync_q  <= '0;
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      pcnt_q  <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
    end
  end

  assign rst_n_out = rst_n_q;
  assign seq_busy  = busy_q;

`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] cause_q, cause_d;

  always_comb begin
    cause_d = cause_q;
    if (sync_ok && sw_rst_req) cause_d = 2'b10;
    else if (cause_clr)        cause_d = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) cause_q <= 2'b01;
    else         cause_q <= cause_d;
  end

  assign rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: randomized stimulus checked against an event-time reference model.
module tb_reset_sequencer;
  localparam int NCH     = 4;
  localparam int SYNC    = 2;
  localparam int STRETCH = 16;
  localparam int GAP     = 8;
  localparam int PULSE   = 4;
  localparam int FAR     = 1 << 30;

  logic           clk = 1'b0;
  logic           rst_in;
  logic           sw_rst_req;
  logic [NCH-1:0] ch_rst_req;
  logic [NCH-1:0] rst_n_out;
  logic           seq_busy;
`ifdef RESET_SEQ_CAUSE_EN
  logic           cause_clr;
  logic [1:0]     rst_cause;
  logic [1:0]     exp_cause;
`endif

  int nvec = 0;
  int nerr = 0;
  // Model: e = edge count, t0 = sequence start edge, s_edge = first synchronised edge,
  // pend[i] = edge at which channel i's soft pulse ends.
  int e;
  int t0;
  int s_edge;
  int pend [NCH];

  reset_sequencer #(
    .NUM_CH(NCH), .SYNC_STAGES(SYNC), .STRETCH_CYCLES(STRETCH),
    .STAGE_GAP(GAP), .CH_PULSE(PULSE)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .sw_rst_req(sw_rst_req),
    .ch_rst_req(ch_rst_req),
    .rst_n_out(rst_n_out),
    .seq_busy(seq_busy)
`ifdef RESET_SEQ_CAUSE_EN
    ,
    .cause_clr(cause_clr),
    .rst_cause(rst_cause)
`endif
  );

  always #5 clk = ~clk;

  function automatic int t_last();
    return t0 + STRETCH + (NCH - 1) * GAP;
  endfunction

  function automatic logic [NCH-1:0] exp_rst();
    logic [NCH-1:0] v;
    for (int k = 0; k < NCH; k++)
      v[k] = (e >= t0 + STRETCH + k * GAP) && (e >= pend[k]);
    return v;
  endfunction

  function automatic logic exp_busy();
    return e < t_last();
  endfunction

  function automatic logic [NCH-1:0] rand_ch(input int pct);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++)
      if ($urandom_range(99) < pct) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    t0 = FAR;
    s_edge = FAR;
    for (int i = 0; i < NCH; i++) pend[i] = 0;
`ifdef RESET_SEQ_CAUSE_EN
    exp_cause = 2'b01;
`endif
  endtask

  task automatic model_release();
    s_edge = e + 1 + SYNC;
    t0 = s_edge;
  endtask

  task automatic model_edge(input logic sw, input logic [NCH-1:0] ch, input logic clr);
    logic run;
    if (!rst_in) return;
    run = (e > t_last());
    if (sw && e >= s_edge) begin
      t0 = e;
      for (int i = 0; i < NCH; i++) pend[i] = 0;
`ifdef RESET_SEQ_CAUSE_EN
      exp_cause = 2'b10;
`endif
    end else begin
      if (run)
        for (int i = 0; i < NCH; i++) if (ch[i]) pend[i] = e + PULSE;
`ifdef RESET_SEQ_CAUSE_EN
      if (clr) exp_cause = 2'b00;
`endif
    end
  endtask

  // Drives inputs from the negedge, advances one posedge, returns at the next negedge.
  task automatic cyc(input logic sw, input logic [NCH-1:0] ch, input logic clr);
    sw_rst_req = sw;
    ch_rst_req = ch;
`ifdef RESET_SEQ_CAUSE_EN
    cause_clr = clr;
`endif
    @(posedge clk);
    e++;
    model_edge(sw, ch, clr);
    @(negedge clk);
    sw_rst_req = 1'b0;
    ch_rst_req = '0;
`ifdef RESET_SEQ_CAUSE_EN
    cause_clr = 1'b0;
`endif
  endtask

  task automatic test_reset();
    logic [NCH-1:0] plan;
    model_reset();
    e = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, rand_ch(50), 1'b0);
      nvec++;
      if (rst_n_out !== '0 || seq_busy !== 1'b1) begin
        nerr++;
        $display("FAIL reset_hold: rst_n_out=%b busy=%b, expected 0000/1", rst_n_out, seq_busy);
      end
    end
    e = 0;
    rst_in = 1'b1;
    model_release();
`ifdef RESET_SEQ_CAUSE_EN
    nvec++;
    if (rst_cause !== 2'b01) begin
      nerr++;
      $display("FAIL cause_por: rst_cause=%b, expected 01", rst_cause);
    end
`endif
    for (int c = 0; c < 50; c++) begin
      cyc(1'b0, (e < 40) ? 4'b1111 : rand_ch(10), 1'b0);
      plan = (e < 19) ? 4'b0000 : (e < 27) ? 4'b0001 : (e < 35) ? 4'b0011 :
             (e < 43) ? 4'b0111 : 4'b1111;
      if (e <= 43) begin
        nvec++;
        if (rst_n_out !== plan || seq_busy !== (e < 43)) begin
          nerr++;
          $display("FAIL por_plan: edge %0d rst_n_out=%b busy=%b, expected %b/%b",
                   e, rst_n_out, seq_busy, plan, (e < 43));
        end
      end
      nvec++;
      if (rst_n_out !== exp_rst() || seq_busy !== exp_busy()) begin
        nerr++;
        $display("FAIL por_model: edge %0d rst_n_out=%b busy=%b, expected %b/%b",
                 e, rst_n_out, seq_busy, exp_rst(), exp_busy());
      end
    end
  endtask

  task automatic test_ch_pulse();
    int t;
    logic [NCH-1:0] want;
    for (int c = 0; c < 8; c++) cyc(1'b0, '0, 1'b0);
    t = e + 1;
    cyc(1'b0, 4'b0100, 1'b0);
    for (int c = 0; c < 7; c++) begin
      want = (e < t + PULSE) ? 4'b1011 : 4'b1111;
      nvec++;
      if (rst_n_out !== want || seq_busy !== 1'b0) begin
        nerr++;
        $display("FAIL ch_pulse: edge T+%0d rst_n_out=%b busy=%b, expected %b/0", e - t, rst_n_out, seq_busy, want);
      end
      cyc(1'b0, '0, 1'b0);
    end
    t = e + 1;
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    for (int c = 0; c < 6; c++) begin
      want = (e < t + 6) ? 4'b1011 : 4'b1111;
      nvec++;
      if (rst_n_out !== want) begin
        nerr++;
        $display("FAIL ch_extend: edge T+%0d rst_n_out=%b, expected %b", e - t, rst_n_out, want);
      end
      cyc(1'b0, '0, 1'b0);
    end
    for (int c = 0; c < 120; c++) begin
      cyc(1'b0, rand_ch(12), 1'b0);
      nvec++;
      if (rst_n_out !== exp_rst() || seq_busy !== exp_busy()) begin
        nerr++;
        $display("FAIL ch_random: edge %0d rst_n_out=%b busy=%b, expected %b/%b",
                 e, rst_n_out, seq_busy, exp_rst(), exp_busy());
      end
    end
    for (int c = 0; c < 8; c++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic test_sw_reseq();
    int t;
    t = e + 1;
    cyc(1'b1, '0, 1'b0);
    for (int c = 0; c < 45; c++) begin
      nvec++;
      if (rst_n_out !== exp_rst() || seq_busy !== exp_busy()) begin
        nerr++;
        $display("FAIL sw_model: edge T+%0d rst_n_out=%b busy=%b, expected %b/%b",
                 e - t, rst_n_out, seq_busy, exp_rst(), exp_busy());
      end
      if (e == t || e == t + 15 || e == t + 16 || e == t + 40) begin
        nvec++;
        if (rst_n_out !== ((e == t + 40) ? 4'b1111 : (e == t + 16) ? 4'b0001 : 4'b0000) ||
            seq_busy !== (e != t + 40)) begin
          nerr++;
          $display("FAIL sw_plan: edge T+%0d rst_n_out=%b busy=%b", e - t, rst_n_out, seq_busy);
        end
      end
      cyc(1'b0, rand_ch(10), 1'b0);
    end
    t = e + 1;
    cyc(1'b1, '0, 1'b0);
    while (e < t + 9) cyc(1'b0, rand_ch(20), 1'b0);
    cyc(1'b1, '0, 1'b0);
    for (int c = 0; c < 48; c++) begin
      nvec++;
      if (rst_n_out !== exp_rst() || seq_busy !== exp_busy()) begin
        nerr++;
        $display("FAIL sw_retrig: edge T+%0d rst_n_out=%b busy=%b, expected %b/%b",
                 e - t, rst_n_out, seq_busy, exp_rst(), exp_busy());
      end
      if (e == t + 25 || e == t + 26) begin
        nvec++;
        if (rst_n_out[0] !== (e == t + 26)) begin
          nerr++;
          $display("FAIL sw_retrig_ch0: edge T+%0d rst_n_out[0]=%b, expected %b", e - t, rst_n_out[0], (e == t + 26));
        end
      end
      cyc(1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_priority();
    int t;
    t = e + 1;
    cyc(1'b1, 4'b0001, 1'b0);
    for (int c = 0; c < 50; c++) begin
      nvec++;
      if (rst_n_out !== exp_rst() || seq_busy !== exp_busy()) begin
        nerr++;
        $display("FAIL priority: edge T+%0d rst_n_out=%b busy=%b, expected %b/%b",
                 e - t, rst_n_out, seq_busy, exp_rst(), exp_busy());
      end
      cyc(1'b0, '0, 1'b0);
    end
    nvec++;
    if (rst_n_out !== 4'b1111) begin
      nerr++;
      $display("FAIL priority_end: rst_n_out=%b, expected 1111", rst_n_out);
    end
  endtask

  task automatic test_async_mid();
    int n;
    bit found;
    found = 1'b0;
    cyc(1'b1, '0, 1'b0);
    for (int c = 0; c < 80 && !found; c++) begin
      if (rst_n_out === 4'b0011) found = 1'b1;
      else cyc(1'b0, '0, 1'b0);
    end
    nvec++;
    if (!found) begin
      nerr++;
      $display("FAIL async_wait: rst_n_out never reached 0011, last=%b", rst_n_out);
    end
    #1 rst_in = 1'b0;
    #1;
    nvec++;
    if (rst_n_out !== 4'b0000 || seq_busy !== 1'b1) begin
      nerr++;
      $display("FAIL async_now: rst_n_out=%b busy=%b, expected 0000/1", rst_n_out, seq_busy);
    end
    #1 rst_in = 1'b1;
    model_reset();
    model_release();
    n = s_edge;
    for (int c = 0; c < 50; c++) begin
      cyc(1'b0, rand_ch(10), 1'b0);
      nvec++;
      if (rst_n_out !== exp_rst() || seq_busy !== exp_busy()) begin
        nerr++;
        $display("FAIL async_reseq: edge %0d rst_n_out=%b busy=%b, expected %b/%b",
                 e, rst_n_out, seq_busy, exp_rst(), exp_busy());
      end
      if (e == n + STRETCH - 1 || e == n + STRETCH) begin
        nvec++;
        if (rst_n_out !== ((e == n + STRETCH) ? 4'b0001 : 4'b0000)) begin
          nerr++;
          $display("FAIL async_ch0: edge S+%0d rst_n_out=%b", e - n, rst_n_out);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cyc(($urandom_range(99) < 2), rand_ch(8), 1'b0);
      nvec++;
      if (rst_n_out !== exp_rst() || seq_busy !== exp_busy()) begin
        nerr++;
        $display("FAIL random: edge %0d rst_n_out=%b busy=%b, expected %b/%b",
                 e, rst_n_out, seq_busy, exp_rst(), exp_busy());
      end
    end
  endtask

`ifdef RESET_SEQ_CAUSE_EN
  task automatic test_cause();
    logic sw;
    logic clr;
    logic [1:0] plan;
    for (int c = 0; c < 4; c++) begin
      sw  = (c == 1 || c == 3);
      clr = (c != 1);
      plan = sw ? 2'b10 : 2'b00;
      cyc(sw, rand_ch(10), clr);
      nvec++;
      if (rst_cause !== plan || rst_cause !== exp_cause) begin
        nerr++;
        $display("FAIL cause: step %0d rst_cause=%b, expected %b", c, rst_cause, plan);
      end
    end
    for (int c = 0; c < 200; c++) begin
      cyc(($urandom_range(99) < 3), rand_ch(8), ($urandom_range(99) < 5));
      nvec++;
      if (rst_cause !== exp_cause) begin
        nerr++;
        $display("FAIL cause_random: edge %0d rst_cause=%b, expected %b", e, rst_cause, exp_cause);
      end
    end
  endtask
`endif

  initial begin
    rst_in     = 1'b1;
    sw_rst_req = 1'b0;
    ch_rst_req = '0;
`ifdef RESET_SEQ_CAUSE_EN
    cause_clr  = 1'b0;
`endif
    #2 rst_in = 1'b0;
    test_reset();
    test_ch_pulse();
    test_sw_reseq();
    test_priority();
    test_async_mid();
    test_random();
`ifdef RESET_SEQ_CAUSE_EN
    test_cause();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
